// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one bit per clock, LSB first
// Optional subtract mode (a - b) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_a, op_b, acc;
  logic [IDX_W-1:0] idx;
  logic             c, sub_q, sub_in;
  logic             accept, last;
  logic             bit_a, bit_b, bit_s, bit_c;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (idx == LAST_IDX);

  // Subtraction inverts b and seeds the carry with 1 (two's complement).
  assign bit_a = op_a[0];
  assign bit_b = op_b[0] ^ sub_q;
  assign bit_s = bit_a ^ bit_b ^ c;
  assign bit_c = (bit_a & bit_b) | (bit_a & c) | (bit_b & c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      idx   <= '0;
      c     <= 1'b0;
      sub_q <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b;
      acc   <= '0;
      idx   <= '0;
      c     <= sub_in;
      sub_q <= sub_in;
    end else if (state == RUN) begin
      op_a <= op_a >> 1;
      op_b <= op_b >> 1;
      c    <= bit_c;
      // New bit enters at the MSB so bit 0 lands in acc[0] after WIDTH shifts.
      acc  <= {bit_s, acc[WIDTH-1:1]};
      if (last) begin
        sum   <= {bit_s, acc[WIDTH-1:1]};
        carry <= bit_c;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH 8 and 2)
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start8 = 1'b0, start2 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  logic       busy8, done8, carry8, busy2, done2, carry2;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8 = 1'b0;
  logic       sub2 = 1'b0;
`endif

  int checks = 0;
  int passes = 0;
  int cyc;
  bit stable;
  int pulses;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .carry(carry2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op8(input logic [7:0] va, input logic [7:0] vb);
    a8 = va; b8 = vb; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Counts edges after acceptance until done; also flags any sum/carry change before done.
  task automatic wait_done8(output int n, output bit ok);
    logic [8:0] snap;
    snap = {carry8, sum8};
    ok = 1'b1;
    n = 0;
    while (n < 40) begin
      tick();
      n = n + 1;
      if (done8) break;
      if ({carry8, sum8} !== snap) ok = 1'b0;
    end
  endtask

  task automatic wait_done2(output int n);
    n = 0;
    while (n < 20) begin
      tick();
      n = n + 1;
      if (done2) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",  busy8,  0);
    check("rst_done",  done8,  0);
    check("rst_sum",   sum8,   0);
    check("rst_carry", carry8, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // 0x35 + 0x0A
    start_op8(8'h35, 8'h0A);
    check("op1_busy", busy8, 1);
    wait_done8(cyc, stable);
    check("op1_latency", cyc, 8);
    check("op1_stable", stable, 1);
    check("op1_sum", sum8, 8'h3F);
    check("op1_carry", carry8, 0);
    tick();
    check("op1_done_pulse", done8, 0);
    check("op1_idle", busy8, 0);

    // 0xFF + 0x01 overflow, then hold
    start_op8(8'hFF, 8'h01);
    wait_done8(cyc, stable);
    check("op2_latency", cyc, 8);
    check("op2_stable", stable, 1);
    check("op2_sum", sum8, 8'h00);
    check("op2_carry", carry8, 1);
    repeat (3) tick();
    check("op2_hold_sum", sum8, 8'h00);
    check("op2_hold_carry", carry8, 1);

    // start held high with new operands during RUN and DONE
    start_op8(8'h12, 8'h34);
    start8 = 1'b1; a8 = 8'hF0; b8 = 8'hF0;
    wait_done8(cyc, stable);
    check("op3_latency", cyc, 8);
    check("op3_sum", sum8, 8'h46);
    check("op3_carry", carry8, 0);
    tick();
    check("op3_single_pulse", done8, 0);
    check("op3_idle_gap", busy8, 0);
    tick();
    check("op4_accepted", busy8, 1);
    start8 = 1'b0;
    wait_done8(cyc, stable);
    check("op4_latency", cyc, 8);
    check("op4_sum", sum8, 8'hE0);
    check("op4_carry", carry8, 1);
    tick();

    // reset at bit 4 of an 8-bit op
    start_op8(8'h35, 8'h0A);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  busy8,  0);
    check("midrst_done",  done8,  0);
    check("midrst_sum",   sum8,   0);
    check("midrst_carry", carry8, 0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      tick();
      if (done8 || busy8) pulses = pulses + 1;
    end
    check("midrst_no_done", pulses, 0);

    // WIDTH=2 exhaustive
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      logic [2:0] e;
      v = 4'(i);
      a2 = v[3:2];
      b2 = v[1:0];
      e = {1'b0, v[3:2]} + {1'b0, v[1:0]};
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      wait_done2(cyc);
      check($sformatf("w2_lat_%0d", i), cyc, 2);
      check($sformatf("w2_res_%0d", i), {carry2, sum2}, e);
      tick();
    end

`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b1;
    start_op8(8'h10, 8'h01);
    wait_done8(cyc, stable);
    check("sub1_sum", sum8, 8'h0F);
    check("sub1_carry", carry8, 1);
    tick();
    start_op8(8'h01, 8'h02);
    wait_done8(cyc, stable);
    check("sub2_sum", sum8, 8'hFF);
    check("sub2_carry", carry8, 0);
    tick();
    sub8 = 1'b0;
    start_op8(8'h80, 8'h80);
    wait_done8(cyc, stable);
    check("add_nosub_sum", sum8, 8'h00);
    check("add_nosub_carry", carry8, 1);
    tick();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request an operation; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; latched on the accepted start.
REQ-006 b  input  WIDTH  operand B; latched on the accepted start.
REQ-007 busy  output  1  high in RUN and DONE; operation in progress.
REQ-008 done  output  1  one-cycle pulse; result valid and updated this cycle.
REQ-009 sum  output  WIDTH  result bits; registered, held until next completion.
REQ-010 carry  output  1  carry-out of MSB; registered, held until next completion.

Function
REQ-011 FSM states IDLE, RUN, DONE; IDLE -> RUN on edge sampling start=1; RUN -> DONE on the edge processing bit WIDTH-1; DONE -> IDLE unconditionally on next edge.
REQ-012 Accepting edge (E0): latch a, b, clear internal carry, clear bit index, busy=1.
REQ-013 Edges E1..EWIDTH: process one bit per edge, LSB first, using a full-adder cell: s_i = a_i ^ b_i ^ c, c' = majority(a_i, b_i, c).
REQ-014 Partial results accumulate in an internal shift register; sum/carry outputs do not change during RUN.
REQ-015 On EWIDTH: sum <= full WIDTH-bit result, carry <= final carry, done=1, state DONE.
REQ-016 On EWIDTH+1: done=0, busy=0, state IDLE; latency start-sample to done = WIDTH clock edges exactly.
REQ-017 start while busy=1 (RUN or DONE) is ignored; no queuing; back-to-back start earliest at the edge after DONE (throughput one op per WIDTH+2 cycles).
REQ-018 Changes on a/b after E0 do not affect the in-flight operation.
REQ-019 Arithmetic modulo 2^WIDTH; carry reports overflow of the unsigned sum.
REQ-020 Bit-index counter width ceil(log2(WIDTH)); index never exceeds WIDTH-1.

Reset
REQ-021 rst_n=0 forces IDLE immediately regardless of clk: busy=0, done=0, sum=0, carry=0, internal operands/carry/index cleared.
REQ-022 Reset mid-RUN or in DONE discards the operation; no done pulse is produced for it.
REQ-023 First start is accepted on the first rising edge with rst_n=1 and start=1.

Configuration
REQ-024 Macro SERIAL_ADDER_SUB_EN: when defined, adds input port sub (1 bit), latched with a/b at E0.
REQ-025 With SERIAL_ADDER_SUB_EN and latched sub=1: compute a - b as a + ~b + 1 (internal carry initialised to 1, b inverted); carry=1 means no borrow (a >= b unsigned).
REQ-026 With SERIAL_ADDER_SUB_EN and sub=0, and whenever the macro is undefined: addition per REQ-013; without the macro the sub port does not exist.

Verification
REQ-027 WIDTH=8, a=0x35, b=0x0A, start one cycle -> done exactly 8 edges after sampling, sum=0x3F, carry=0.
REQ-028 WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, carry=1; sum/carry held after done until next completion.
REQ-029 WIDTH=2, exhaustive loop over all 16 {a,b} pairs, one op each -> sum={a+b}[1:0], carry={a+b}[2] for every pair.
REQ-030 Start re-asserted during RUN and DONE with new operands -> ignored; single done pulse with original result; start held high -> next op accepted at edge after DONE.
REQ-031 rst_n pulled low at bit 4 of an 8-bit op -> busy=0, done=0, sum=0, carry=0 immediately; no done pulse follows.
REQ-032 SERIAL_ADDER_SUB_EN defined, WIDTH=8: sub=1, a=0x10, b=0x01 -> sum=0x0F, carry=1; a=0x01, b=0x02 -> sum=0xFF, carry=0.
